// File: rtl/rw_read_arbiter_pkg.sv
// Shared swarm types and constants for the RW-object read-port arbiter.
package rw_read_arbiter_pkg;

    localparam int THREAD_ID_W  = 8;
    localparam int CACHE_ADDR_W = 12;

    typedef logic [THREAD_ID_W-1:0]  id_t;
    typedef logic [CACHE_ADDR_W-1:0] cache_addr_t;

    localparam int RW_ARB_PORTS     = 2;
    localparam int RW_ARB_MAX_OUTST = 16;

    // IDLE: arbitrate freely each cycle; HOLD: AR presented but not yet accepted.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Round-robin successor of a port index.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rw_read_arbiter_chk.sv
// Simulation checks for the per-port outstanding counters.
module rw_read_arbiter_chk #(
    parameter int N_PORTS   = 2,
    parameter int MAX_OUTST = 16,
    parameter int CNT_W     = 5
) (
    input logic                     clk,
    input logic                     rst,
    input logic [N_PORTS-1:0]       dec,
    input logic [N_PORTS*CNT_W-1:0] outstanding
);

    for (genvar g = 0; g < N_PORTS; g++) begin : g_chk
        // A routed response must never arrive for a port with nothing in flight.
        a_no_underflow : assert property (@(posedge clk) disable iff (rst)
            !(dec[g] && (outstanding[g*CNT_W +: CNT_W] == '0)));
        // A count can never exceed the per-port cap.
        a_no_overflow : assert property (@(posedge clk) disable iff (rst)
            (int'(outstanding[g*CNT_W +: CNT_W]) <= MAX_OUTST));
    end

endmodule

// File: rtl/rw_read_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins (one-hot).
module rw_read_arbiter_rr_arbiter #(
    parameter int N = 2,
    localparam int P_W = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [P_W-1:0] ptr,
    output logic [N-1:0]   grant
);

    logic found_s;
    logic sel_s;

    // Scan ports in rotated order starting at ptr; the first request found wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        sel_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < N; p++) begin
                sel_s    = req[p] && !found_s && (((int'(ptr) + i) % N) == p);
                grant[p] = grant[p] | sel_s;
                found_s  = found_s | sel_s;
            end
        end
    end

endmodule

// File: rtl/rw_read_arbiter.sv
// Shares the L1 RW-object read port between N_PORTS requesters: round-robin
// AR arbitration with port tag in the upper arid bits, R routed back by tag,
// per-port outstanding read caps.
module rw_read_arbiter
    import rw_read_arbiter_pkg::*;
#(
    parameter int N_PORTS   = RW_ARB_PORTS,
    parameter int ID_W      = THREAD_ID_W,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = RW_ARB_MAX_OUTST,
    localparam int P_W      = $clog2(N_PORTS),
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req_arvalid,
    output logic [N_PORTS-1:0]         req_arready,
    input  logic [N_PORTS*ADDR_W-1:0]  req_araddr,
    input  logic [N_PORTS*ID_W-1:0]    req_arid,
    output logic [N_PORTS-1:0]         req_rvalid,
    input  logic [N_PORTS-1:0]         req_rready,
    output logic [ID_W-1:0]            req_rid,
    output logic [DATA_W-1:0]          req_rdata,
    output cache_addr_t                req_rindex,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    output logic [ADDR_W-1:0]          m_araddr,
    output logic [P_W+ID_W-1:0]        m_arid,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    input  logic [P_W+ID_W-1:0]        m_rid,
    input  logic [DATA_W-1:0]          m_rdata,
    input  cache_addr_t                m_rindex,
    output logic [N_PORTS*CNT_W-1:0]   outstanding,
    output logic                       err_bad_rid
);

    arb_state_e          state_r;
    arb_state_e          state_nxt_s;
    logic [P_W-1:0]      grant_port_r;
    logic [P_W-1:0]      grant_port_nxt_s;
    logic [P_W-1:0]      rr_ptr_r;
    logic [P_W-1:0]      rr_ptr_nxt_s;

    logic [CNT_W-1:0]    cnt_r [N_PORTS];
    logic [N_PORTS-1:0]  eligible_s;
    logic [N_PORTS-1:0]  arb_onehot_s;
    logic                arb_any_s;
    logic [P_W-1:0]      arb_port_s;
    logic                cur_valid_s;
    logic [P_W-1:0]      cur_port_s;
    logic                ar_hs_s;
    logic [ID_W-1:0]     cur_id_s;

    logic [P_W-1:0]      r_port_s;
    logic                r_bad_s;
    logic [N_PORTS-1:0]  r_hs_s;
    logic                err_bad_rid_r;

    // A port may compete only while it is below its in-flight cap.
    always_comb begin
        eligible_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            eligible_s[p] = req_arvalid[p] && (cnt_r[p] < CNT_W'(MAX_OUTST));
        end
    end

    rw_read_arbiter_rr_arbiter #(.N(N_PORTS)) u_rr (
        .req   (eligible_s),
        .ptr   (rr_ptr_r),
        .grant (arb_onehot_s)
    );

    // One-hot grant to index; HOLD overrides arbitration so AR stays stable.
    always_comb begin
        arb_any_s  = |arb_onehot_s;
        arb_port_s = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            arb_port_s = arb_onehot_s[p] ? P_W'(p) : arb_port_s;
        end
        cur_valid_s = (state_r == ARB_HOLD) ? 1'b1 : arb_any_s;
        cur_port_s  = (state_r == ARB_HOLD) ? grant_port_r : arb_port_s;
        ar_hs_s     = cur_valid_s && m_arready;
    end

    // Memory-side AR mux and per-port ready, zero added latency.
    always_comb begin
        m_araddr    = '0;
        cur_id_s    = '0;
        req_arready = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            m_araddr       = (cur_port_s == P_W'(p)) ? req_araddr[p*ADDR_W +: ADDR_W] : m_araddr;
            cur_id_s       = (cur_port_s == P_W'(p)) ? req_arid[p*ID_W +: ID_W] : cur_id_s;
            req_arready[p] = ar_hs_s && (cur_port_s == P_W'(p));
        end
        m_arvalid = cur_valid_s;
        m_arid    = {cur_port_s, cur_id_s};
    end

    // Arbitration FSM next state: latch the grant on a stall, advance rr_ptr on handshake.
    always_comb begin
        state_nxt_s      = state_r;
        grant_port_nxt_s = grant_port_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (arb_any_s && !m_arready) begin
                    state_nxt_s      = ARB_HOLD;
                    grant_port_nxt_s = arb_port_s;
                end else if (ar_hs_s) begin
                    rr_ptr_nxt_s = P_W'(rr_next(int'(cur_port_s), N_PORTS));
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_HOLD: begin
                if (m_arready) begin
                    state_nxt_s  = ARB_IDLE;
                    rr_ptr_nxt_s = P_W'(rr_next(int'(grant_port_r), N_PORTS));
                end else begin
                    state_nxt_s = ARB_HOLD;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ARB_IDLE;
            grant_port_r <= '0;
            rr_ptr_r     <= '0;
        end else begin
            state_r      <= state_nxt_s;
            grant_port_r <= grant_port_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
        end
    end

    // R routing by tag; out-of-range tags are swallowed with ready held high.
    always_comb begin
        r_port_s   = m_rid[P_W+ID_W-1 -: P_W];
        r_bad_s    = (int'(r_port_s) >= N_PORTS);
        m_rready   = r_bad_s;
        req_rvalid = '0;
        r_hs_s     = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            req_rvalid[p] = m_rvalid && (r_port_s == P_W'(p));
            m_rready      = (r_port_s == P_W'(p)) ? req_rready[p] : m_rready;
            r_hs_s[p]     = m_rvalid && req_rready[p] && (r_port_s == P_W'(p));
        end
        req_rid    = m_rid[ID_W-1:0];
        req_rdata  = m_rdata;
        req_rindex = m_rindex;
    end

    // Sticky flag for responses carrying a port tag that does not exist.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_bad_rid_r <= 1'b0;
        end else if (m_rvalid && r_bad_s) begin
            err_bad_rid_r <= 1'b1;
        end else begin
            err_bad_rid_r <= err_bad_rid_r;
        end
    end

    assign err_bad_rid = err_bad_rid_r;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
        logic inc_s;
        logic dec_s;

        assign inc_s = ar_hs_s && (cur_port_s == P_W'(g));
        assign dec_s = r_hs_s[g];

        // In-flight count: saturating at the cap and at zero; simultaneous inc/dec cancel.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r[g] <= '0;
            end else if (inc_s && !dec_s && (cnt_r[g] < CNT_W'(MAX_OUTST))) begin
                cnt_r[g] <= cnt_r[g] + CNT_W'(1);
            end else if (dec_s && !inc_s && (cnt_r[g] != '0)) begin
                cnt_r[g] <= cnt_r[g] - CNT_W'(1);
            end else begin
                cnt_r[g] <= cnt_r[g];
            end
        end

        assign outstanding[g*CNT_W +: CNT_W] = cnt_r[g];
    end

    rw_read_arbiter_chk #(
        .N_PORTS   (N_PORTS),
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .dec         (r_hs_s),
        .outstanding (outstanding)
    );

endmodule

// File: tb/tb_rw_read_arbiter.sv
// Directed bench for rw_read_arbiter: vector table plus hand-written
// sequences for stall, cap, and bad-tag corner cases.
module tb_rw_read_arbiter;
    import rw_read_arbiter_pkg::*;

    localparam int DW = 512;
    localparam logic [31:0] ADDR0 = 32'h1000_0000;
    localparam logic [31:0] ADDR1 = 32'h2000_0000;
    localparam logic [63:0] DPAT  = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-port instance
    logic [1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
    logic [63:0]   req_araddr;
    logic [15:0]   req_arid;
    logic [7:0]    req_rid;
    logic [DW-1:0] req_rdata;
    cache_addr_t   req_rindex;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0]   m_araddr;
    logic [8:0]    m_arid, m_rid;
    logic [DW-1:0] m_rdata;
    cache_addr_t   m_rindex;
    logic [9:0]    outstanding;
    logic          err_bad_rid;

    // Three-port instance
    logic [2:0]    req_arvalid3, req_arready3, req_rvalid3, req_rready3;
    logic [95:0]   req_araddr3;
    logic [23:0]   req_arid3;
    logic [7:0]    req_rid3;
    logic [DW-1:0] req_rdata3;
    cache_addr_t   req_rindex3;
    logic          m_arvalid3, m_arready3, m_rvalid3, m_rready3;
    logic [31:0]   m_araddr3;
    logic [9:0]    m_arid3, m_rid3;
    logic [14:0]   outstanding3;
    logic          err_bad_rid3;

    rw_read_arbiter dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arid(req_arid),
        .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rid(req_rid), .req_rdata(req_rdata), .req_rindex(req_rindex),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rindex(m_rindex),
        .outstanding(outstanding), .err_bad_rid(err_bad_rid)
    );

    rw_read_arbiter #(.N_PORTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid3), .req_arready(req_arready3),
        .req_araddr(req_araddr3), .req_arid(req_arid3),
        .req_rvalid(req_rvalid3), .req_rready(req_rready3),
        .req_rid(req_rid3), .req_rdata(req_rdata3), .req_rindex(req_rindex3),
        .m_arvalid(m_arvalid3), .m_arready(m_arready3),
        .m_araddr(m_araddr3), .m_arid(m_arid3),
        .m_rvalid(m_rvalid3), .m_rready(m_rready3),
        .m_rid(m_rid3), .m_rdata(m_rdata), .m_rindex(m_rindex),
        .outstanding(outstanding3), .err_bad_rid(err_bad_rid3)
    );

    typedef struct packed {
        logic [1:0] arv;
        logic       ardy;
        logic       rv;
        logic [8:0] rid;
        logic [1:0] rrdy;
        logic       e_arv;
        logic [8:0] e_arid;
        logic [1:0] e_arrdy;
        logic [1:0] e_rv;
        logic       e_mrrdy;
        logic [4:0] e_c0;
        logic [4:0] e_c1;
    } vec_t;

    vec_t vecs [14];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [1:0] arv, input logic ardy, input logic rv,
                                input logic [8:0] rid, input logic [1:0] rrdy,
                                input logic e_arv, input logic [8:0] e_arid,
                                input logic [1:0] e_arrdy, input logic [1:0] e_rv,
                                input logic e_mrrdy, input logic [4:0] e_c0,
                                input logic [4:0] e_c1);
        vec_t v;
        v.arv = arv; v.ardy = ardy; v.rv = rv; v.rid = rid; v.rrdy = rrdy;
        v.e_arv = e_arv; v.e_arid = e_arid; v.e_arrdy = e_arrdy; v.e_rv = e_rv;
        v.e_mrrdy = e_mrrdy; v.e_c0 = e_c0; v.e_c1 = e_c1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        // Both ports request continuously, ready high: grants alternate.
        vecs[0]  = mk(2'b11, 1'b1, 1'b0, 9'h000, 2'b00, 1'b1, 9'h011, 2'b01, 2'b00, 1'b0, 5'd1, 5'd0);
        vecs[1]  = mk(2'b11, 1'b1, 1'b0, 9'h000, 2'b00, 1'b1, 9'h122, 2'b10, 2'b00, 1'b0, 5'd1, 5'd1);
        vecs[2]  = mk(2'b11, 1'b1, 1'b0, 9'h000, 2'b00, 1'b1, 9'h011, 2'b01, 2'b00, 1'b0, 5'd2, 5'd1);
        vecs[3]  = mk(2'b11, 1'b1, 1'b0, 9'h000, 2'b00, 1'b1, 9'h122, 2'b10, 2'b00, 1'b0, 5'd2, 5'd2);
        // Response {0,2A} back-pressured for two cycles, then accepted.
        vecs[4]  = mk(2'b00, 1'b0, 1'b1, 9'h02A, 2'b00, 1'b0, 9'h000, 2'b00, 2'b01, 1'b0, 5'd2, 5'd2);
        vecs[5]  = mk(2'b00, 1'b0, 1'b1, 9'h02A, 2'b00, 1'b0, 9'h000, 2'b00, 2'b01, 1'b0, 5'd2, 5'd2);
        vecs[6]  = mk(2'b00, 1'b0, 1'b1, 9'h02A, 2'b01, 1'b0, 9'h000, 2'b00, 2'b01, 1'b1, 5'd1, 5'd2);
        vecs[7]  = mk(2'b00, 1'b0, 1'b0, 9'h02A, 2'b00, 1'b0, 9'h000, 2'b00, 2'b00, 1'b0, 5'd1, 5'd2);
        // Same-cycle AR and R on one port, then on crossed ports.
        vecs[8]  = mk(2'b01, 1'b1, 1'b1, 9'h02A, 2'b01, 1'b1, 9'h011, 2'b01, 2'b01, 1'b1, 5'd1, 5'd2);
        vecs[9]  = mk(2'b10, 1'b1, 1'b1, 9'h105, 2'b10, 1'b1, 9'h122, 2'b10, 2'b10, 1'b1, 5'd1, 5'd2);
        vecs[10] = mk(2'b01, 1'b1, 1'b1, 9'h133, 2'b10, 1'b1, 9'h011, 2'b01, 2'b10, 1'b1, 5'd2, 5'd1);
        // Drain.
        vecs[11] = mk(2'b00, 1'b0, 1'b1, 9'h000, 2'b01, 1'b0, 9'h000, 2'b00, 2'b01, 1'b1, 5'd1, 5'd1);
        vecs[12] = mk(2'b00, 1'b0, 1'b1, 9'h1C0, 2'b10, 1'b0, 9'h000, 2'b00, 2'b10, 1'b1, 5'd1, 5'd0);
        vecs[13] = mk(2'b00, 1'b0, 1'b1, 9'h000, 2'b01, 1'b0, 9'h000, 2'b00, 2'b01, 1'b1, 5'd0, 5'd0);

        rst = 1'b1;
        req_arvalid = 2'b00; req_rready = 2'b00;
        req_araddr = {ADDR1, ADDR0}; req_arid = {8'h22, 8'h11};
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = 9'h000;
        m_rdata = {8{DPAT}}; m_rindex = 12'hABC;
        req_arvalid3 = 3'b000; req_rready3 = 3'b000;
        req_araddr3 = {32'h3000_0000, ADDR1, ADDR0}; req_arid3 = {8'h33, 8'h22, 8'h11};
        m_arready3 = 1'b0; m_rvalid3 = 1'b0; m_rid3 = 10'h000;

        tick();
        tick();
        chk("reset m_arvalid", 64'(m_arvalid), 64'd0);
        chk("reset req_arready", 64'(req_arready), 64'd0);
        chk("reset req_rvalid", 64'(req_rvalid), 64'd0);
        chk("reset outstanding", 64'(outstanding), 64'd0);
        chk("reset err_bad_rid", 64'(err_bad_rid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req_arvalid = vecs[i].arv;
            m_arready   = vecs[i].ardy;
            m_rvalid    = vecs[i].rv;
            m_rid       = vecs[i].rid;
            req_rready  = vecs[i].rrdy;
            settle();
            chk($sformatf("v%0d m_arvalid", i), 64'(m_arvalid), 64'(vecs[i].e_arv));
            if (vecs[i].e_arv) begin
                chk($sformatf("v%0d m_arid", i), 64'(m_arid), 64'(vecs[i].e_arid));
                chk($sformatf("v%0d m_araddr", i), 64'(m_araddr),
                    64'(vecs[i].e_arid[8] ? ADDR1 : ADDR0));
            end
            chk($sformatf("v%0d req_arready", i), 64'(req_arready), 64'(vecs[i].e_arrdy));
            chk($sformatf("v%0d req_rvalid", i), 64'(req_rvalid), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d m_rready", i), 64'(m_rready), 64'(vecs[i].e_mrrdy));
            if (vecs[i].rv) begin
                chk($sformatf("v%0d req_rid", i), 64'(req_rid), 64'(vecs[i].rid[7:0]));
            end
            tick();
            chk($sformatf("v%0d outst0", i), 64'(outstanding[4:0]), 64'(vecs[i].e_c0));
            chk($sformatf("v%0d outst1", i), 64'(outstanding[9:5]), 64'(vecs[i].e_c1));
        end
        m_rvalid = 1'b0; req_rready = 2'b00;

        // Stall: port0 held on AR for three cycles while port1 joins.
        for (int c = 0; c < 4; c++) begin
            req_arvalid = (c == 0) ? 2'b01 : 2'b11;
            m_arready   = (c == 3) ? 1'b1 : 1'b0;
            settle();
            chk($sformatf("stall%0d m_arvalid", c), 64'(m_arvalid), 64'd1);
            chk($sformatf("stall%0d m_araddr", c), 64'(m_araddr), 64'(ADDR0));
            chk($sformatf("stall%0d m_arid", c), 64'(m_arid), 64'h011);
            chk($sformatf("stall%0d req_arready", c), 64'(req_arready),
                (c == 3) ? 64'd1 : 64'd0);
            tick();
        end
        settle();
        chk("post-stall m_araddr", 64'(m_araddr), 64'(ADDR1));
        chk("post-stall req_arready", 64'(req_arready), 64'd2);
        tick();
        chk("post-stall outstanding", 64'(outstanding), 64'({5'd1, 5'd1}));
        req_arvalid = 2'b00; m_arready = 1'b0;

        // Drain both, also checking the broadcast data and index.
        m_rvalid = 1'b1; m_rid = 9'h05A; req_rready = 2'b01;
        settle();
        chk("bcast req_rid", 64'(req_rid), 64'h5A);
        chk("bcast rdata lo", req_rdata[63:0], DPAT);
        chk("bcast rdata hi", req_rdata[DW-1 -: 64], DPAT);
        chk("bcast rindex", 64'(req_rindex), 64'hABC);
        tick();
        m_rid = 9'h100; req_rready = 2'b10;
        tick();
        m_rvalid = 1'b0; req_rready = 2'b00;
        chk("drain outstanding", 64'(outstanding), 64'd0);

        // Cap: port1 fills to 16, is refused, then one R reopens it.
        req_arvalid = 2'b10; m_arready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            settle();
            chk($sformatf("fill%0d req_arready", c), 64'(req_arready), 64'd2);
            tick();
        end
        chk("cap outst1=16", 64'(outstanding[9:5]), 64'd16);
        settle();
        chk("cap m_arvalid", 64'(m_arvalid), 64'd0);
        chk("cap req_arready", 64'(req_arready), 64'd0);
        tick();
        chk("cap holds 16", 64'(outstanding[9:5]), 64'd16);
        m_rvalid = 1'b1; m_rid = 9'h177; req_rready = 2'b10;
        settle();
        chk("cap R req_arready", 64'(req_arready), 64'd0);
        chk("cap R req_rvalid", 64'(req_rvalid), 64'd2);
        tick();
        chk("cap after R", 64'(outstanding[9:5]), 64'd15);
        m_rvalid = 1'b0; req_rready = 2'b00;
        settle();
        chk("reopen req_arready", 64'(req_arready), 64'd2);
        tick();
        chk("reopen outst1", 64'(outstanding[9:5]), 64'd16);
        req_arvalid = 2'b00; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rid = 9'h101; req_rready = 2'b10;
        for (int c = 0; c < 16; c++) begin
            tick();
        end
        m_rvalid = 1'b0; req_rready = 2'b00;
        chk("cap drained", 64'(outstanding), 64'd0);

        // Three-port instance: bad response tag.
        req_arvalid3 = 3'b100; m_arready3 = 1'b1;
        settle();
        chk("p3 m_arid", 64'(m_arid3), 64'h233);
        tick();
        req_arvalid3 = 3'b000; m_arready3 = 1'b0;
        m_rvalid3 = 1'b1; m_rid3 = 10'h355; req_rready3 = 3'b000;
        settle();
        chk("bad m_rready", 64'(m_rready3), 64'd1);
        chk("bad req_rvalid", 64'(req_rvalid3), 64'd0);
        tick();
        m_rvalid3 = 1'b0;
        chk("bad err set", 64'(err_bad_rid3), 64'd1);
        chk("bad counters", 64'(outstanding3), 64'({5'd1, 5'd0, 5'd0}));
        tick();
        chk("bad err sticky", 64'(err_bad_rid3), 64'd1);
        chk("2p err clear", 64'(err_bad_rid), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst err clear", 64'(err_bad_rid3), 64'd0);
        chk("rst counters", 64'(outstanding3), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
